// File: rtl/mips_debug_run_ctrl.sv
// Run-control unit for the MIPS debug path: free run, N-cycle step,
// pause, PC breakpoints, end-of-program detection and cycle counting.
module mips_debug_run_ctrl #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16,
  parameter int NUM_BP    = 4,
  parameter int CYC_WIDTH = 32,
  localparam int IDX_W    = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_cmd_valid,
  input  logic [2:0]           i_cmd,
  input  logic [CNT_WIDTH-1:0] i_step_count,
  input  logic                 i_bp_wr,
  input  logic [IDX_W-1:0]     i_bp_idx,
  input  logic [PC_WIDTH-1:0]  i_bp_addr,
  input  logic                 i_bp_en,
  input  logic [PC_WIDTH-1:0]  i_pc,
  input  logic                 i_halt,
  output logic                 o_cpu_en,
  output logic [1:0]           o_state,
  output logic                 o_done,
  output logic                 o_cmd_ack,
  output logic                 o_cmd_err,
  output logic                 o_bp_hit,
  output logic [CYC_WIDTH-1:0] o_cycles
);

  localparam logic [1:0] S_HALT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_END  = 2'd3;

  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_skip;
  logic                 r_ack;
  logic                 r_err;
  logic                 r_bp_hit;
  logic [CYC_WIDTH-1:0] r_cycles;
  logic [PC_WIDTH-1:0]  r_bp_addr [NUM_BP];
  logic [NUM_BP-1:0]    r_bp_en;

  logic [1:0]           w_nxt_state;
  logic [CNT_WIDTH-1:0] w_nxt_cnt;
  logic                 w_nxt_skip;
  logic                 w_ack;
  logic                 w_err;
  logic                 w_bp_stop;
  logic                 w_clr;
  logic                 w_match;
  logic                 w_bp_hit;
  logic                 w_cpu_en;

  logic w_run, w_step, w_pause, w_clear, w_ill;

  assign w_run   = i_cmd_valid && (i_cmd == 3'd1);
  assign w_step  = i_cmd_valid && (i_cmd == 3'd2);
  assign w_pause = i_cmd_valid && (i_cmd == 3'd3);
  assign w_clear = i_cmd_valid && (i_cmd == 3'd4);
  assign w_ill   = i_cmd_valid && (i_cmd > 3'd4);

  always_comb begin
    w_match = 1'b0;
    for (int b = 0; b < NUM_BP; b++) begin
      if (r_bp_en[b] && (r_bp_addr[b] == i_pc)) w_match = 1'b1;
    end
  end

  // The skip flag lets a resume fetch the instruction it stopped on.
  assign w_bp_hit = w_match && !r_skip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_HALT;
      r_cnt    <= '0;
      r_skip   <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_bp_hit <= 1'b0;
      r_cycles <= '0;
      r_bp_en  <= '0;
      for (int b = 0; b < NUM_BP; b++) r_bp_addr[b] <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      r_skip   <= w_nxt_skip;
      r_ack    <= w_ack;
      r_err    <= w_err;
      r_bp_hit <= w_bp_stop;
      if (w_clr) r_cycles <= '0;
      else if (w_cpu_en && (r_cycles != '1))
        r_cycles <= r_cycles + CYC_WIDTH'(1);
      for (int b = 0; b < NUM_BP; b++) begin
        if (i_bp_wr && (i_bp_idx == IDX_W'(b))) begin
          r_bp_addr[b] <= i_bp_addr;
          r_bp_en[b]   <= i_bp_en;
        end
      end
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_skip  = r_skip;
    w_ack       = 1'b0;
    w_err       = 1'b0;
    w_bp_stop   = 1'b0;
    w_clr       = 1'b0;
    unique case (r_state)
      S_HALT: begin
        if (w_run) begin
          w_nxt_state = S_RUN;
          w_nxt_skip  = 1'b1;
          w_ack       = 1'b1;
        end else if (w_step) begin
          w_nxt_state = S_STEP;
          w_nxt_cnt   = (i_step_count == '0) ? CNT_WIDTH'(1)
                                             : i_step_count;
          w_ack       = 1'b1;
        end else if (w_clear) begin
          w_clr = 1'b1;
          w_ack = 1'b1;
        end else if (w_pause || w_ill) begin
          w_err = 1'b1;
        end
      end
      S_RUN, S_STEP: begin
        if (r_state == S_RUN) w_nxt_skip = 1'b0;
        if (r_state == S_STEP && r_cnt != '0)
          w_nxt_cnt = r_cnt - CNT_WIDTH'(1);
        if (w_pause) w_ack = 1'b1;
        else if (w_run || w_step || w_clear || w_ill) w_err = 1'b1;
        if (i_halt) begin
          w_nxt_state = S_END;
        end else if (w_pause) begin
          w_nxt_state = S_HALT;
        end else if (r_state == S_RUN && w_bp_hit) begin
          w_nxt_state = S_HALT;
          w_bp_stop   = 1'b1;
        end else if (r_state == S_STEP && r_cnt <= CNT_WIDTH'(1)) begin
          w_nxt_state = S_HALT;
        end
      end
      default: begin
        if (w_clear) begin
          w_nxt_state = S_HALT;
          w_clr       = 1'b1;
          w_ack       = 1'b1;
        end else if (w_run || w_step || w_pause || w_ill) begin
          w_err = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    w_cpu_en  = (r_state == S_STEP) ||
                ((r_state == S_RUN) && !w_bp_hit);
    o_cpu_en  = w_cpu_en;
    o_state   = r_state;
    o_done    = (r_state == S_END);
    o_cmd_ack = r_ack;
    o_cmd_err = r_err;
    o_bp_hit  = r_bp_hit;
    o_cycles  = r_cycles;
  end

endmodule

// File: tb/tb_mips_debug_run_ctrl.sv
// Directed bench for mips_debug_run_ctrl with a 4-bit cycle counter
// so saturation is reachable in a short run.
module tb_mips_debug_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmd_valid;
  logic [2:0]  i_cmd;
  logic [15:0] i_step_count;
  logic        i_bp_wr;
  logic [1:0]  i_bp_idx;
  logic [31:0] i_bp_addr;
  logic        i_bp_en;
  logic [31:0] i_pc;
  logic        i_halt;
  logic        o_cpu_en;
  logic [1:0]  o_state;
  logic        o_done;
  logic        o_cmd_ack;
  logic        o_cmd_err;
  logic        o_bp_hit;
  logic [3:0]  o_cycles;

  int nvec = 0;
  int nmis = 0;
  int en_cnt, ack_cnt;
  logic en, hit, stop_seen;
  logic [31:0] stop_pc;

  mips_debug_run_ctrl #(
    .PC_WIDTH(32), .CNT_WIDTH(16), .NUM_BP(4), .CYC_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .i_step_count(i_step_count),
    .i_bp_wr(i_bp_wr), .i_bp_idx(i_bp_idx),
    .i_bp_addr(i_bp_addr), .i_bp_en(i_bp_en),
    .i_pc(i_pc), .i_halt(i_halt),
    .o_cpu_en(o_cpu_en), .o_state(o_state), .o_done(o_done),
    .o_cmd_ack(o_cmd_ack), .o_cmd_err(o_cmd_err),
    .o_bp_hit(o_bp_hit), .o_cycles(o_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [2:0] c, input logic [15:0] n);
    i_cmd_valid  = 1'b1;
    i_cmd        = c;
    i_step_count = n;
    tick();
    i_cmd_valid  = 1'b0;
    i_cmd        = 3'd0;
  endtask

  initial begin
    rst = 1'b1; i_cmd_valid = 1'b0; i_cmd = 3'd0; i_step_count = '0;
    i_bp_wr = 1'b0; i_bp_idx = '0; i_bp_addr = '0; i_bp_en = 1'b0;
    i_pc = '0; i_halt = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(o_state), 0);
    chk("rst_cpu_en", 32'(o_cpu_en), 0);
    chk("rst_cycles", 32'(o_cycles), 0);
    chk("rst_flags", {o_done, o_cmd_ack, o_cmd_err, o_bp_hit}, 0);
    rst = 1'b0;
    tick();

    // STEP 3
    cmd(3'd2, 16'd3);
    chk("step3_state", 32'(o_state), 2);
    en_cnt = 0; ack_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_cpu_en) en_cnt++;
      if (o_cmd_ack) ack_cnt++;
      tick();
    end
    chk("step3_en_cycles", en_cnt, 3);
    chk("step3_acks", ack_cnt, 1);
    chk("step3_back_halt", 32'(o_state), 0);
    chk("step3_cycles", 32'(o_cycles), 3);

    // STEP 0 behaves as 1
    cmd(3'd2, 16'd0);
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_cpu_en) en_cnt++;
      tick();
    end
    chk("step0_en_cycles", en_cnt, 1);
    chk("step0_cycles", 32'(o_cycles), 4);

    cmd(3'd3, 16'd0);
    chk("pause_halt_err", 32'(o_cmd_err), 1);
    chk("pause_halt_ack", 32'(o_cmd_ack), 0);
    chk("pause_halt_state", 32'(o_state), 0);
    tick();
    chk("err_one_pulse", 32'(o_cmd_err), 0);
    cmd(3'd5, 16'd0);
    chk("illegal_err", 32'(o_cmd_err), 1);
    cmd(3'd0, 16'd0);
    chk("nop_quiet", {o_cmd_ack, o_cmd_err}, 0);
    cmd(3'd4, 16'd0);
    chk("clear_ack", 32'(o_cmd_ack), 1);
    chk("clear_cycles", 32'(o_cycles), 0);

    // breakpoint at 0x10
    i_bp_wr = 1'b1; i_bp_idx = 2'd0; i_bp_addr = 32'h10; i_bp_en = 1'b1;
    tick();
    i_bp_wr = 1'b0;
    i_pc = 32'h0;
    cmd(3'd1, 16'd0);
    hit = 1'b0; stop_seen = 1'b0; stop_pc = '1;
    for (int i = 0; i < 12; i++) begin
      #1;
      en = o_cpu_en;
      if (!en && !stop_seen) begin
        stop_seen = 1'b1;
        stop_pc = i_pc;
      end
      tick();
      if (en) i_pc = i_pc + 32'd4;
      if (o_bp_hit) begin
        hit = 1'b1;
        break;
      end
    end
    chk("bp_hit_pulse", 32'(hit), 1);
    chk("bp_stop_pc", stop_pc, 32'h10);
    chk("bp_state_halt", 32'(o_state), 0);
    chk("bp_cycles", 32'(o_cycles), 4);
    tick();
    chk("bp_hit_one_pulse", 32'(o_bp_hit), 0);

    // resume from the breakpoint PC
    cmd(3'd1, 16'd0);
    chk("resume_ack", 32'(o_cmd_ack), 1);
    chk("resume_fetch_bp_pc", 32'(o_cpu_en), 1);
    tick();
    i_pc = 32'h14;
    #1;
    chk("resume_continue_en", 32'(o_cpu_en), 1);
    chk("resume_state", 32'(o_state), 1);

    // i_halt beats PAUSE
    i_halt = 1'b1;
    cmd(3'd3, 16'd0);
    i_halt = 1'b0;
    chk("halt_end_state", 32'(o_state), 3);
    chk("halt_done", 32'(o_done), 1);
    chk("halt_cpu_en", 32'(o_cpu_en), 0);
    cmd(3'd1, 16'd0);
    chk("end_run_err", 32'(o_cmd_err), 1);
    chk("end_stays", 32'(o_state), 3);
    cmd(3'd4, 16'd0);
    chk("end_clear_ack", 32'(o_cmd_ack), 1);
    chk("end_clear_state", 32'(o_state), 0);
    chk("end_clear_cycles", 32'(o_cycles), 0);
    chk("end_clear_done", 32'(o_done), 0);

    // saturation of the 4-bit counter
    i_pc = 32'h100;
    cmd(3'd1, 16'd0);
    repeat (10) tick();
    chk("sat_mid_cycles", 32'(o_cycles), 10);
    repeat (10) tick();
    cmd(3'd3, 16'd0);
    chk("sat_pause_state", 32'(o_state), 0);
    chk("sat_pause_en", 32'(o_cpu_en), 0);
    chk("sat_cycles", 32'(o_cycles), 15);

    // async reset mid-STEP
    cmd(3'd2, 16'd10);
    repeat (5) tick();
    chk("mid_step_state", 32'(o_state), 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'(o_state), 0);
    chk("arst_cpu_en", 32'(o_cpu_en), 0);
    chk("arst_cycles", 32'(o_cycles), 0);
    chk("arst_flags", {o_done, o_cmd_ack, o_cmd_err, o_bp_hit}, 0);
    #1 rst = 1'b0;
    i_pc = 32'h10;
    cmd(3'd1, 16'd0);
    tick();
    chk("arst_bp_cleared", 32'(o_cpu_en), 1);
    chk("arst_run_state", 32'(o_state), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/mips_debug_run_ctrl.md
# mips_debug_run_ctrl

Parametrised run-control unit sitting between the debug UART front-end and the MIPS pipeline. It replaces the single-level `i_step` input of the MIPS top with the following execution controls:
- free run
- N-cycle stepping
- pause
- hardware PC breakpoints
- end-of-program detection

It also keeps a saturating count of enabled cycles for the debug dump. Its `o_cpu_en` output drives the MIPS `i_step` pipeline-enable input.

## Interface
Parameters:
- `PC_WIDTH`, 32, width of the PC and breakpoint addresses.
- `CNT_WIDTH`, 16, width of the step-count request.
- `NUM_BP`, 4, number of breakpoint registers (1..16).
- `CYC_WIDTH`, 32, width of the enabled-cycle counter.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_cmd_valid`  in  1  command strobe, sampled every cycle.
- `i_cmd`  in  3  command code: 0 NOP, 1 RUN, 2 STEP, 3 PAUSE, 4 CLEAR; codes 5-7 are illegal.
- `i_step_count`  in  `CNT_WIDTH`  number of cycles for STEP, sampled with the command; 0 is treated as 1.
- `i_bp_wr`  in  1  breakpoint write strobe.
- `i_bp_idx`  in  `$clog2(NUM_BP)` (min 1)  breakpoint entry to write.
- `i_bp_addr`  in  `PC_WIDTH`  breakpoint address.
- `i_bp_en`  in  1  enable bit for the written entry.
- `i_pc`  in  `PC_WIDTH`  current fetch PC from IF.
- `i_halt`  in  1  HALT instruction has reached WB.
- `o_cpu_en`  out  1  pipeline enable.
- `o_state`  out  2  0 HALT, 1 RUN, 2 STEP, 3 END.
- `o_done`  out  1  high while in END.
- `o_cmd_ack`  out  1  one-cycle pulse when a command is accepted.
- `o_cmd_err`  out  1  one-cycle pulse when a command is rejected or illegal.
- `o_bp_hit`  out  1  one-cycle pulse on the cycle a breakpoint stops RUN.
- `o_cycles`  out  `CYC_WIDTH`  count of cycles with `o_cpu_en`=1, saturating.

## Operation
**State machine.** States are HALT, RUN, STEP and END. Reset state is HALT.

**Command acceptance.**
- HALT:
  - RUN goes to RUN.
  - STEP loads the counter (0 is loaded as 1) and goes to STEP.
  - CLEAR zeroes `o_cycles` and stays in HALT.
  - PAUSE is rejected.
- RUN / STEP:
  - PAUSE goes to HALT.
  - RUN, STEP and CLEAR are rejected.
- END:
  - CLEAR zeroes `o_cycles` and goes to HALT.
  - All other commands are rejected.
- NOP never acks and never errs. Illegal codes always err.

**Pipeline enable.** `o_cpu_en` = (STEP) or (RUN and not `bp_hit`).
- `bp_hit` = any enabled entry with `addr == i_pc`, and `bp_skip` = 0.
- `bp_skip` is set when a RUN command is accepted. It is cleared after the first cycle in RUN, so a resume from a breakpoint PC fetches that instruction.

**Breakpoint stop.** A `bp_hit` in RUN forces HALT on the next edge and pulses `o_bp_hit`. Breakpoints are ignored in STEP.

**Step counting.** In STEP the counter decrements every cycle. When the counter is 1, the next state is HALT. This gives exactly N enabled cycles.

**End of program.** `i_halt` in RUN or STEP goes to END. `i_halt` is ignored in HALT and END.

**Priority on the same cycle:** `i_halt` > PAUSE > breakpoint > step-count expiry.

**Breakpoint writes.** Writes are accepted in any state and take effect from the next cycle. Reset clears all entries to addr 0, disabled.

**Cycle counter.** `o_cycles` increments on every edge where `o_cpu_en`=1 and holds at all-ones. CLEAR has priority over increment.

## Timing
**Reset values:**
- state HALT; `o_cpu_en`=0, `o_done`=0.
- `o_cmd_ack`/`o_cmd_err`/`o_bp_hit` = 0.
- `o_cycles`=0, step counter = 0, `bp_skip`=0.

**Command latency.** A command sampled at edge k changes state at edge k, so `o_cpu_en` rises in cycle k+1. `o_cmd_ack`/`o_cmd_err` are registered and high during cycle k+1.

**PAUSE.** `o_cpu_en` remains high in the cycle PAUSE is presented and drops the following cycle.

**Breakpoint.** `o_cpu_en` drops combinationally in the same cycle `i_pc` matches, so the breakpoint instruction is not fetched. `o_bp_hit` is registered and high in the next cycle.

**Output timing.** `o_state`, `o_done` and `o_cycles` are registered. `o_cpu_en` is the only output with a combinational path, from `i_pc` only.

**Reset mid-operation.** An asserted `rst` immediately forces all reset values, including in the middle of RUN or STEP.

## Test plan
- Reset, then STEP with `i_step_count`=3 → `o_cpu_en` high exactly 3 cycles, back to HALT, `o_cycles`=3, one `o_cmd_ack`.
- STEP with count 0 → exactly 1 enabled cycle. Then PAUSE in HALT → `o_cmd_err` pulse, state stays HALT.
- Set bp0 = 0x0000_0010 enabled; RUN with `i_pc` advancing by 4 from 0 → `o_cpu_en` low when `i_pc`=0x10, `o_bp_hit` pulse, HALT, `o_cycles`=4. RUN again → 0x10 is fetched and run continues.
- RUN, then `i_halt` and PAUSE presented in the same cycle → END, `o_done`=1. RUN in END → err. CLEAR → HALT, `o_cycles`=0.
- Preload `o_cycles` near saturation (`CYC_WIDTH`=4, run 20 cycles) → holds at 15.
- Assert `rst` mid-STEP with counter 5 → immediate HALT, all outputs at reset values, breakpoints disabled.
